memory_arbiter: RTL and testbench

Arbitrates the single-ported main RAM between the instruction cache and the data cache of the MIPS core. Each cache presents a word-wide request and stalls on its wait line until the arbiter has moved the word through RAM. The data side has fixed priority, bounded by a starvation limit that forces an instruction grant. The block sits between the icache/dcache pair and the RAM model, in place of a direct cache-to-RAM connection.

---
 rtl/memory_arbiter.sv | 118 +++++++++++
 tb/tb_memory_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single-ported main RAM between the icache and
// the dcache. The data side has fixed priority. A streak counter limits how
// many data grants can pass a waiting instruction request before the
// instruction side is forced through.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

  state_t     state, next_state;
  logic [3:0] dstreak, next_dstreak;
  logic       dreq;

  // Saturating increment for the data-grant streak counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign dreq = dREN | dWEN;

  // State and streak registers; reset abandons any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      dstreak <= 4'd0;
    end else begin
      state   <= next_state;
      dstreak <= next_dstreak;
    end
  end

  // Arbitration, RAM steering and completion signalling.
  always_comb begin
    next_state   = state;
    next_dstreak = dstreak;
    iwait        = iREN;
    dwait        = dreq;
    iload        = 32'd0;
    dload        = 32'd0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = 32'd0;
    ramstore     = 32'd0;

    case (state)
      IDLE: begin
        // The streak only means something while an instruction is waiting.
        if (!iREN) next_dstreak = 4'd0;
        if (dreq && (!iREN || (dstreak < LIMIT))) begin
          next_state = DGRANT;
          if (iREN) next_dstreak = sat_inc(dstreak);
        end else if (iREN) begin
          next_state   = IGRANT;
          next_dstreak = 4'd0;
        end
      end

      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          // Request withdrawn: release the RAM without a completion.
          next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait      = 1'b0;
          iload      = ramload;
          next_state = IDLE;
        end
        // BUSY, FREE and ERROR hold the grant and keep driving the RAM.
      end

      DGRANT: begin
        // A write wins over a read when both strobes are up.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait      = 1'b0;
          dload      = dWEN ? 32'd0 : ramload;
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboarded testbench for memory_arbiter: directed sequences queue the
// completions they expect; a negedge monitor pops and compares each one.
module tb_memory_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = FREE;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] load;
  } exp_t;

  exp_t q[$];
  exp_t mon_i;
  exp_t mon_d;

  memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic is_d, input logic [31:0] load);
    exp_t e;
    e.is_d = is_d;
    e.load = load;
    q.push_back(e);
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Two reset edges; returns in cycle 0 of a fresh IDLE with RST low.
  task automatic do_reset();
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  // Monitor: every completion seen on either side must match the queue head.
  always @(negedge CLK) begin
    if (!RST) begin
      if (iREN && !iwait) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_i_completion: got iload %h, required no completion", iload);
        end else begin
          mon_i = q.pop_front();
          check("completion_side_i", 32'(mon_i.is_d), 32'd0);
          check("iload", iload, mon_i.load);
        end
      end
      if ((dREN || dWEN) && !dwait) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_d_completion: got dload %h, required no completion", dload);
        end else begin
          mon_d = q.pop_front();
          check("completion_side_d", 32'(mon_d.is_d), 32'd1);
          check("dload", dload, mon_d.load);
        end
      end
    end
  end

  initial begin
    // Reset with an instruction request pending.
    RST = 1'b1; iREN = 1'b1;
    cyc();
    cyc();
    @(negedge CLK);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd0);
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_iload", iload, 32'd0);

    // Instruction read: three BUSY cycles, then ACCESS in cycle 4.
    do_reset();
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
    push(1'b0, 32'h8C01_0004);
    @(negedge CLK);
    check("ird_c0_ramREN", 32'(ramREN), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      ramstate = BUSY;
      @(negedge CLK);
      check("ird_busy_ramaddr", ramaddr, 32'h40);
      check("ird_busy_ramREN", 32'(ramREN), 32'd1);
      check("ird_busy_iwait", 32'(iwait), 32'd1);
    end
    cyc();
    ramstate = ACCESS; ramload = 32'h8C01_0004;
    @(negedge CLK);
    check("ird_c4_iwait", 32'(iwait), 32'd0);
    cyc();
    ramstate = FREE; ramload = 32'h0;
    @(negedge CLK);
    check("ird_c5_idle_ramREN", 32'(ramREN), 32'd0);
    check("ird_c5_iwait", 32'(iwait), 32'd1);
    check("ird_c5_iload", iload, 32'd0);
    cyc();
    iREN = 1'b0;
    cyc();

    // Conflict: data wins, then the instruction goes in cycle 3.
    do_reset();
    iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h100;
    ramstate = ACCESS; ramload = 32'h1111_1111;
    push(1'b1, 32'h1111_1111);
    push(1'b0, 32'h2222_2222);
    cyc();
    @(negedge CLK);
    check("cfl_c1_ramaddr", ramaddr, 32'h100);
    check("cfl_c1_dwait", 32'(dwait), 32'd0);
    check("cfl_c1_iwait", 32'(iwait), 32'd1);
    cyc();
    dREN = 1'b0; ramload = 32'h2222_2222;
    @(negedge CLK);
    check("cfl_c2_ramREN", 32'(ramREN), 32'd0);
    cyc();
    @(negedge CLK);
    check("cfl_c3_ramaddr", ramaddr, 32'h200);
    check("cfl_c3_iwait", 32'(iwait), 32'd0);
    cyc();
    iREN = 1'b0;
    cyc();

    // Starvation: continuous requests, four data grants then one instruction.
    do_reset();
    iREN = 1'b1; iaddr = 32'h400; dREN = 1'b1; daddr = 32'h500;
    ramstate = ACCESS;
    for (int c = 1; c <= 19; c += 2)
      push((c == 9 || c == 19) ? 1'b0 : 1'b1, 32'hA5A5_0000 + 32'(c));
    for (int c = 0; c < 20; c++) begin
      if (c > 0) cyc();
      ramload = 32'hA5A5_0000 + 32'(c);
    end
    cyc();
    iREN = 1'b0; dREN = 1'b0;
    cyc();
    check("starve_queue_drained", 32'(q.size()), 32'd0);

    // Write with two ERROR cycles before ACCESS.
    do_reset();
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h300; dstore = 32'hDEAD_BEEF;
    ramstate = ERROR; ramload = 32'h1234_5678;
    push(1'b1, 32'h0);
    for (int k = 1; k <= 2; k++) begin
      cyc();
      @(negedge CLK);
      check("wr_err_ramWEN", 32'(ramWEN), 32'd1);
      check("wr_err_ramREN", 32'(ramREN), 32'd0);
      check("wr_err_ramstore", ramstore, 32'hDEAD_BEEF);
      check("wr_err_dwait", 32'(dwait), 32'd1);
      check("wr_err_dload", dload, 32'd0);
    end
    cyc();
    ramstate = ACCESS;
    @(negedge CLK);
    check("wr_acc_ramWEN", 32'(ramWEN), 32'd1);
    check("wr_acc_ramREN", 32'(ramREN), 32'd0);
    check("wr_acc_dwait", 32'(dwait), 32'd0);
    cyc();
    dWEN = 1'b0; dREN = 1'b0;
    cyc();

    // Abort: instruction request dropped during BUSY.
    do_reset();
    iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY; ramload = 32'h0BAD_F00D;
    cyc();
    @(negedge CLK);
    check("abt_c1_ramREN", 32'(ramREN), 32'd1);
    cyc();
    iREN = 1'b0;
    @(negedge CLK);
    check("abt_c2_ramREN", 32'(ramREN), 32'd0);
    check("abt_c2_iwait", 32'(iwait), 32'd0);
    cyc();
    iREN = 1'b1; ramstate = ACCESS;
    push(1'b0, 32'h0BAD_F00D);
    @(negedge CLK);
    check("abt_c3_idle_ramREN", 32'(ramREN), 32'd0);
    check("abt_c3_iwait", 32'(iwait), 32'd1);
    cyc();
    @(negedge CLK);
    check("abt_c4_ramREN", 32'(ramREN), 32'd1);
    cyc();
    iREN = 1'b0; ramstate = FREE;
    cyc();
    cyc();
    check("final_queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
